// File: rtl/multi_ch_sync_filter.sv
// Per-channel multi-flop synchronizer followed by a consecutive-sample glitch
// filter, with registered rise/fall pulses aligned to the filtered level.
module multi_ch_sync_filter #(
  parameter int CH       = 4,
  parameter int STAGES   = 2,
  parameter int FILT_LEN = 3,
  parameter int FILT_W   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] async_in,
  input  logic          filt_en,
  output logic [CH-1:0] level_out,
  output logic [CH-1:0] rise_pulse,
  output logic [CH-1:0] fall_pulse,
  output logic          change_any
);

  localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'(FILT_LEN - 1);

  logic [CH-1:0]     sync_q  [STAGES];
  logic [CH-1:0]     sync_d  [STAGES];
  logic [FILT_W-1:0] cnt_q   [CH];
  logic [FILT_W-1:0] cnt_d   [CH];
  logic [CH-1:0]     level_q, level_d;
  logic [CH-1:0]     rise_q, rise_d;
  logic [CH-1:0]     fall_q, fall_d;
  logic              change_q, change_d;
  logic [CH-1:0]     sync_w;

  always_comb begin
    sync_d[0] = async_in;
    for (int k = 1; k < STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    sync_w = sync_q[STAGES-1];

    level_d = level_q;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = '0;
      if (!filt_en) begin
        level_d[i] = sync_w[i];
      end else if (sync_w[i] != level_q[i]) begin
        // A disagreement must persist FILT_LEN consecutive samples to be accepted.
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = sync_w[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    rise_d   = level_d & ~level_q;
    fall_d   = ~level_d & level_q;
    change_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= '0;
      end
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
      end
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= change_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign change_any = change_q;

endmodule
